// File: rtl/regfile_ctrl_if.sv
// Bus bundle between the regfile sequencer and its neighbours: decode (id_*),
// execute (ex_*), writeback (wb_*) and the register file (rf_*).
//
// Handshakes: id_* and ex_* use strict valid/ready. A transfer happens on a
// rising clk edge where valid && ready are both high. The sender holds valid
// and its payload stable until the transfer. ready may depend combinationally
// on valid and the payload. wb_valid has no ready and is taken every cycle it
// is high.
interface regfile_ctrl_if #(
   parameter int AWIDTH = 4,
   parameter int DWIDTH = 16
);
   localparam int NREG = 1 << AWIDTH;

   // decode -> sequencer
   logic              id_valid;
   logic              id_ready;
   logic [AWIDTH-1:0] id_rs_addr;
   logic [AWIDTH-1:0] id_rt_addr;
   logic [AWIDTH-1:0] id_rd_addr;
   logic              id_rd_en;

   // sequencer -> execute
   logic              ex_valid;
   logic              ex_ready;
   logic [DWIDTH-1:0] ex_rs_data;
   logic [DWIDTH-1:0] ex_rt_data;
   logic [AWIDTH-1:0] ex_rd_addr;
   logic              ex_rd_en;

   // writeback -> sequencer
   logic              wb_valid;
   logic [AWIDTH-1:0] wb_addr;
   logic [DWIDTH-1:0] wb_data;

   // sequencer <-> register file
   logic [AWIDTH-1:0] rf_addr_rs;
   logic [AWIDTH-1:0] rf_addr_rt;
   logic [AWIDTH-1:0] rf_addr_rd;
   logic              rf_req_rs;
   logic              rf_req_rt;
   logic              rf_req_rd;
   logic [DWIDTH-1:0] rf_wdata;
   logic [DWIDTH-1:0] rf_rs;
   logic [DWIDTH-1:0] rf_rt;

   // status
   logic              stall;
   logic [NREG-1:0]   sb_busy;

   // Sequencer side
   modport master (
      input  id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rd_en,
      output id_ready,
      output ex_valid, ex_rs_data, ex_rt_data, ex_rd_addr, ex_rd_en,
      input  ex_ready,
      input  wb_valid, wb_addr, wb_data,
      output rf_addr_rs, rf_addr_rt, rf_addr_rd,
      output rf_req_rs, rf_req_rt, rf_req_rd, rf_wdata,
      input  rf_rs, rf_rt,
      output stall, sb_busy
   );

   // Environment side (decode, execute, writeback, register file)
   modport slave (
      output id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rd_en,
      input  id_ready,
      input  ex_valid, ex_rs_data, ex_rt_data, ex_rd_addr, ex_rd_en,
      output ex_ready,
      output wb_valid, wb_addr, wb_data,
      input  rf_addr_rs, rf_addr_rt, rf_addr_rd,
      input  rf_req_rs, rf_req_rt, rf_req_rd, rf_wdata,
      output rf_rs, rf_rt,
      input  stall, sb_busy
   );
endinterface

// File: rtl/regfile_ctrl.sv
// Operand-fetch / writeback sequencer in front of regfile_v2.
// Accepts one decoded instruction at a time. It reads rs/rt through the
// register file's registered read port and presents the operands to execute.
// A busy-bit scoreboard tracks pending destinations and stalls decode on
// RAW/WAW hazards. Writeback is a pure combinational pass-through to the
// register file write port.
module regfile_ctrl #(
   parameter int AWIDTH = 4,
   parameter int DWIDTH = 16
) (
   input  logic                clk,
   input  logic                clear_n,
   regfile_ctrl_if.master      bus,
   output logic [1:0]          state_dbg
);

   localparam int NREG = 1 << AWIDTH;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      CAPTURE = 2'd2,
      VALID   = 2'd3
   } state_t;

   state_t            state;
   state_t            state_next;

   logic [NREG-1:0]   sb_q;
   logic [NREG-1:0]   sb_next;
   logic [NREG-1:0]   wb_clr;
   logic [NREG-1:0]   busy_eff;

   logic              rs_haz;
   logic              rt_haz;
   logic              rd_haz;
   logic              hazard;
   logic              accept;
   logic              sets_rd;

   logic [AWIDTH-1:0] lat_rs;
   logic [AWIDTH-1:0] lat_rt;
   logic [AWIDTH-1:0] lat_rd;
   logic              lat_rd_en;

   logic [DWIDTH-1:0] ex_rs_q;
   logic [DWIDTH-1:0] ex_rt_q;
   logic [AWIDTH-1:0] ex_rd_addr_q;
   logic              ex_rd_en_q;

   // ------------------------------------------------------------------
   // Write path
   // ------------------------------------------------------------------
   // Writeback goes straight to the regfile. r0 is hard-wired, so writes to it
   // are dropped. The strobe is gated by reset so nothing commits while in reset.
   always_comb begin
      bus.rf_req_rd  = clear_n && bus.wb_valid && (bus.wb_addr != '0);
      bus.rf_addr_rd = bus.wb_addr;
      bus.rf_wdata   = bus.wb_data;
   end

   // ------------------------------------------------------------------
   // Scoreboard and hazard detection
   // ------------------------------------------------------------------
   // One-hot clear for the register being written back this cycle.
   always_comb begin
      wb_clr = '0;
      if (bus.wb_valid) begin
         wb_clr[bus.wb_addr] = 1'b1;
      end
   end

   // A writeback in this cycle already releases its register. The value is
   // visible to the FETCH read one cycle later, so an instruction can be
   // accepted in that same cycle without a bypass path.
   assign busy_eff = sb_q & ~wb_clr;

   // r0 never hazards. Its busy bit is never set, but it is excluded explicitly
   // so the intent does not depend on that.
   always_comb begin
      rs_haz = (bus.id_rs_addr != '0) && busy_eff[bus.id_rs_addr];
      rt_haz = (bus.id_rt_addr != '0) && busy_eff[bus.id_rt_addr];
      rd_haz = bus.id_rd_en && (bus.id_rd_addr != '0) && busy_eff[bus.id_rd_addr];
      hazard = rs_haz || rt_haz || rd_haz;
   end

   assign bus.id_ready = (state == IDLE) && !hazard;
   assign bus.stall    = bus.id_valid && (state == IDLE) && hazard;
   assign accept       = bus.id_valid && bus.id_ready;
   assign sets_rd      = accept && bus.id_rd_en && (bus.id_rd_addr != '0);

   // Next scoreboard: clear the written-back bit, then set the new
   // destination. The set comes last so it wins over a same-cycle clear of
   // the same register.
   always_comb begin
      sb_next = busy_eff;
      if (sets_rd) begin
         sb_next[bus.id_rd_addr] = 1'b1;
      end
      sb_next[0] = 1'b0;
   end

   // Scoreboard register. Reset drops every pending destination, including
   // the one claimed by an aborted instruction.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         sb_q <= '0;
      end else begin
         sb_q <= sb_next;
      end
   end

   assign bus.sb_busy = sb_q;

   // ------------------------------------------------------------------
   // Sequencing FSM
   // ------------------------------------------------------------------
   // State register
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. Operands take a fixed FETCH/CAPTURE pair, then sit in
   // VALID until execute takes them.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept)       state_next = FETCH;
         FETCH:                     state_next = CAPTURE;
         CAPTURE:                   state_next = VALID;
         VALID:   if (bus.ex_ready) state_next = IDLE;
         default:                   state_next = IDLE;
      endcase
   end

   assign state_dbg = state;

   // Latch the accepted instruction's register fields for the fetch and
   // execute hand-off.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         lat_rs    <= '0;
         lat_rt    <= '0;
         lat_rd    <= '0;
         lat_rd_en <= 1'b0;
      end else if (accept) begin
         lat_rs    <= bus.id_rs_addr;
         lat_rt    <= bus.id_rt_addr;
         lat_rd    <= bus.id_rd_addr;
         lat_rd_en <= bus.id_rd_en;
      end
   end

   // Read strobes for the registered regfile read port. Data returns in
   // CAPTURE.
   always_comb begin
      bus.rf_req_rs  = (state == FETCH);
      bus.rf_req_rt  = (state == FETCH);
      bus.rf_addr_rs = lat_rs;
      bus.rf_addr_rt = lat_rt;
   end

   // Capture the operands from the regfile. r0 reads as zero regardless of
   // what the regfile returns. The registers load only in CAPTURE, so they
   // hold steady through VALID under backpressure.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         ex_rs_q      <= '0;
         ex_rt_q      <= '0;
         ex_rd_addr_q <= '0;
         ex_rd_en_q   <= 1'b0;
      end else if (state == CAPTURE) begin
         ex_rs_q      <= (lat_rs == '0) ? '0 : bus.rf_rs;
         ex_rt_q      <= (lat_rt == '0) ? '0 : bus.rf_rt;
         ex_rd_addr_q <= lat_rd;
         ex_rd_en_q   <= lat_rd_en;
      end
   end

   // Execute-side outputs
   always_comb begin
      bus.ex_valid   = (state == VALID);
      bus.ex_rs_data = ex_rs_q;
      bus.ex_rt_data = ex_rt_q;
      bus.ex_rd_addr = ex_rd_addr_q;
      bus.ex_rd_en   = ex_rd_en_q;
   end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl with a behavioural regfile_v2 model.
// Inputs change 1 ns after the rising edge. Outputs are checked a few ns later,
// well away from the edge.
module tb_regfile_ctrl;

   localparam int AWIDTH = 4;
   localparam int DWIDTH = 16;

   logic       clk = 1'b0;
   logic       clear_n;
   logic [1:0] state_dbg;

   int checks = 0;
   int errors = 0;

   regfile_ctrl_if #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) bus ();

   regfile_ctrl #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
      .clk       (clk),
      .clear_n   (clear_n),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // Clock
   always #5 clk = ~clk;

   // Register file model: write commits at the edge, read data registered
   // and valid the cycle after the request.
   logic [DWIDTH-1:0] regs [16] = '{default: '0};

   always @(posedge clk) begin
      if (bus.rf_req_rd) regs[bus.rf_addr_rd] <= bus.rf_wdata;
      if (bus.rf_req_rs) bus.rf_rs <= regs[bus.rf_addr_rs];
      if (bus.rf_req_rt) bus.rf_rt <= regs[bus.rf_addr_rt];
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_wb(input logic v, input logic [3:0] a, input logic [15:0] d);
      bus.wb_valid = v;
      bus.wb_addr  = a;
      bus.wb_data  = d;
   endtask

   task automatic drive_id(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                           input logic [3:0] rd, input logic rd_en);
      bus.id_valid   = v;
      bus.id_rs_addr = rs;
      bus.id_rt_addr = rt;
      bus.id_rd_addr = rd;
      bus.id_rd_en   = rd_en;
   endtask

   initial begin
      clear_n      = 1'b0;
      bus.ex_ready = 1'b1;
      drive_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
      drive_wb(1'b1, 4'd2, 16'h00AA);
      #3;
      // Reset state. The write strobe is held low even with a WB pending.
      check("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
      check("rst_sb_busy", 32'(bus.sb_busy), 32'd0);
      check("rst_state", 32'(state_dbg), 32'd0);
      check("rst_rf_req_rd", 32'(bus.rf_req_rd), 32'd0);
      drive_wb(1'b0, 4'd0, 16'h0);
      step();
      clear_n = 1'b1;
      step();

      // ---- Basic issue: r1=1, r2=2, then rs=1 rt=2 rd=3
      drive_wb(1'b1, 4'd1, 16'h0001);
      #2 check("wb1_rf_req_rd", 32'(bus.rf_req_rd), 32'd1);
      step();
      drive_wb(1'b1, 4'd2, 16'h0002);
      step();
      drive_wb(1'b0, 4'd0, 16'h0);
      drive_id(1'b1, 4'd1, 4'd2, 4'd3, 1'b1);
      #2 check("t2_id_ready", 32'(bus.id_ready), 32'd1);
      step();                                   // N+1
      drive_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
      #2;
      check("t2_rf_req_rs", 32'(bus.rf_req_rs), 32'd1);
      check("t2_rf_req_rt", 32'(bus.rf_req_rt), 32'd1);
      check("t2_rf_addr_rs", 32'(bus.rf_addr_rs), 32'd1);
      check("t2_sb_busy", 32'(bus.sb_busy), 32'h0008);
      step();                                   // N+2
      #2 check("t2_ex_valid_n2", 32'(bus.ex_valid), 32'd0);
      step();                                   // N+3
      #2;
      check("t2_ex_valid", 32'(bus.ex_valid), 32'd1);
      check("t2_ex_rs", 32'(bus.ex_rs_data), 32'h0001);
      check("t2_ex_rt", 32'(bus.ex_rt_data), 32'h0002);
      check("t2_ex_rd_addr", 32'(bus.ex_rd_addr), 32'd3);
      check("t2_ex_rd_en", 32'(bus.ex_rd_en), 32'd1);
      step();                                   // back to IDLE (ex_ready=1)
      #2 check("t2_ex_valid_done", 32'(bus.ex_valid), 32'd0);

      // ---- RAW on r3, released by a same-cycle WB
      #1 drive_id(1'b1, 4'd3, 4'd0, 4'd4, 1'b0);
      #1;
      check("t3_stall", 32'(bus.stall), 32'd1);
      check("t3_id_ready", 32'(bus.id_ready), 32'd0);
      step();
      drive_wb(1'b1, 4'd3, 16'h0008);
      #2;
      check("t3_stall_wb", 32'(bus.stall), 32'd0);
      check("t3_id_ready_wb", 32'(bus.id_ready), 32'd1);
      step();
      drive_wb(1'b0, 4'd0, 16'h0);
      drive_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
      #2 check("t3_sb_busy", 32'(bus.sb_busy), 32'h0000);
      step();
      step();
      #2;
      check("t3_ex_valid", 32'(bus.ex_valid), 32'd1);
      check("t3_ex_rs", 32'(bus.ex_rs_data), 32'h0008);
      check("t3_ex_rt", 32'(bus.ex_rt_data), 32'h0000);
      step();

      // ---- Set wins: make r3 busy, then reissue rd=3 alongside WB to r3
      drive_id(1'b1, 4'd0, 4'd0, 4'd3, 1'b1);
      step();
      drive_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
      step();
      step();
      step();
      step();                                   // IDLE, r3 busy
      #2 check("t4_sb_pre", 32'(bus.sb_busy), 32'h0008);
      drive_id(1'b1, 4'd0, 4'd0, 4'd3, 1'b1);
      drive_wb(1'b1, 4'd3, 16'h0033);
      #1 check("t4_id_ready", 32'(bus.id_ready), 32'd1);
      step();
      drive_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
      drive_wb(1'b0, 4'd0, 16'h0);
      #2 check("t4_sb_busy", 32'(bus.sb_busy), 32'h0008);
      step();
      step();
      step();
      // Retire r3
      drive_wb(1'b1, 4'd3, 16'h0033);
      step();
      drive_wb(1'b0, 4'd0, 16'h0);
      #2 check("t4_sb_clear", 32'(bus.sb_busy), 32'h0000);

      // ---- r0: writes dropped, reads zero, never busy
      drive_wb(1'b1, 4'd0, 16'hFFFF);
      #1 check("t5_rf_req_rd", 32'(bus.rf_req_rd), 32'd0);
      step();
      drive_wb(1'b0, 4'd0, 16'h0);
      drive_id(1'b1, 4'd0, 4'd1, 4'd0, 1'b1);
      #1;
      check("t5_stall", 32'(bus.stall), 32'd0);
      check("t5_id_ready", 32'(bus.id_ready), 32'd1);
      step();
      drive_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
      #2 check("t5_sb_busy", 32'(bus.sb_busy), 32'h0000);
      step();
      step();
      #2;
      check("t5_ex_rs", 32'(bus.ex_rs_data), 32'h0000);
      check("t5_ex_rt", 32'(bus.ex_rt_data), 32'h0001);
      step();

      // ---- Backpressure: hold VALID for 5 cycles
      bus.ex_ready = 1'b0;
      drive_id(1'b1, 4'd1, 4'd2, 4'd5, 1'b1);
      step();
      drive_id(1'b0, 4'd1, 4'd2, 4'd5, 1'b0);
      step();
      step();                                   // VALID
      for (int i = 0; i < 5; i++) begin
         #2;
         check("t6_ex_valid", 32'(bus.ex_valid), 32'd1);
         check("t6_ex_rs", 32'(bus.ex_rs_data), 32'h0001);
         check("t6_ex_rt", 32'(bus.ex_rt_data), 32'h0002);
         check("t6_ex_rd", 32'(bus.ex_rd_addr), 32'd5);
         check("t6_id_ready", 32'(bus.id_ready), 32'd0);
         step();
      end
      bus.ex_ready = 1'b1;
      step();
      #2;
      check("t6_ex_valid_done", 32'(bus.ex_valid), 32'd0);
      check("t6_state_idle", 32'(state_dbg), 32'd0);
      check("t6_id_ready_idle", 32'(bus.id_ready), 32'd1);
      check("t6_sb_busy", 32'(bus.sb_busy), 32'h0020);

      // ---- Reset mid-operation (during FETCH) aborts and clears the scoreboard
      step();
      drive_id(1'b1, 4'd1, 4'd2, 4'd6, 1'b1);
      step();
      drive_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
      #1;
      check("t1_pre_rf_req_rs", 32'(bus.rf_req_rs), 32'd1);
      check("t1_pre_sb", 32'(bus.sb_busy), 32'h0060);
      drive_wb(1'b1, 4'd5, 16'h0055);
      clear_n = 1'b0;
      #1;
      check("t1_ex_valid", 32'(bus.ex_valid), 32'd0);
      check("t1_sb_busy", 32'(bus.sb_busy), 32'h0000);
      check("t1_rf_req_rs", 32'(bus.rf_req_rs), 32'd0);
      check("t1_rf_req_rt", 32'(bus.rf_req_rt), 32'd0);
      check("t1_rf_req_rd", 32'(bus.rf_req_rd), 32'd0);
      check("t1_state", 32'(state_dbg), 32'd0);
      step();
      drive_wb(1'b0, 4'd0, 16'h0);
      clear_n = 1'b1;
      step();
      step();
      #2 check("t1_no_restart", 32'(bus.ex_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
